clk_div_prog: RTL and testbench

Programmable integer clock divider producing a 50%-duty output for both odd and even divisors. It is the parametrised successor to the team's fixed divide-by-3/5/9 divider. The divisor can be changed at runtime and takes effect glitch-free at the next output period boundary. Start and stop requests are also honoured only at period boundaries. It sits in the clock-generation area and feeds slow peripheral clocks and per-period enable strobes.

---
 rtl/clk_div_prog_if.sv | 25 ++
 rtl/clk_div_prog.sv | 106 ++++++++++
 tb/tb_clk_div_prog.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Control and status bundle of the programmable clock divider.
// The master side drives run/divisor requests; the slave side returns the clock and status.
`timescale 1ns/1ps
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             div_wr;
  logic [WIDTH-1:0] div_in;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_cur;
  logic             div_pend;
  logic             div_err;

  modport master (
    output en, div_wr, div_in,
    input  clk_out, tick, div_cur, div_pend, div_err
  );

  modport slave (
    input  en, div_wr, div_in,
    output clk_out, tick, div_cur, div_pend, div_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty integer clock divider, odd and even divisors.
// Divisor, start and stop changes are applied only at output period boundaries.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_prog_if.slave  bus
);
  localparam logic [WIDTH-1:0] RDIV = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
  localparam logic [WIDTH:0]   ONEX = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pnd_q;
  logic             pend_q;
  logic             run;
  logic             p;
  logic             n;
  logic             pe;
  logic             tick_q;
  logic             err_q;

  logic             bnd;
  logic             wr_ok;
  logic             wr_bad;
  logic             p_nx;
  logic [WIDTH-1:0] div_nx;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   half;

  always_comb begin
    bnd     = !run || (cnt == div_q - ONE);
    wr_ok   = bus.div_wr && (bus.div_in >= TWO);
    wr_bad  = bus.div_wr && (bus.div_in < TWO);
    div_nx  = div_q;
    if (wr_ok)
      div_nx = bus.div_in;
    else if (pend_q)
      div_nx = pnd_q;
    cnt_inc = {1'b0, cnt} + ONEX;
    half    = ({1'b0, div_q} + ONEX) >> 1;
    p_nx    = cnt_inc < half;
  end

  // pe carries the even-mode output so a mode switch never races p
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= RDIV - ONE;
      div_q  <= RDIV;
      pnd_q  <= '0;
      pend_q <= 1'b0;
      run    <= 1'b0;
      p      <= 1'b0;
      pe     <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wr_bad;
      if (bnd) begin
        div_q  <= div_nx;
        pend_q <= 1'b0;
        if (bus.en) begin
          run    <= 1'b1;
          cnt    <= '0;
          tick_q <= 1'b1;
          p      <= 1'b1;
          pe     <= ~div_nx[0];
        end else begin
          run    <= 1'b0;
          cnt    <= div_nx - ONE;
          tick_q <= 1'b0;
          p      <= 1'b0;
          pe     <= 1'b0;
        end
      end else begin
        cnt    <= cnt + ONE;
        tick_q <= 1'b0;
        p      <= p_nx;
        pe     <= p_nx & ~div_q[0];
        if (wr_ok) begin
          pnd_q  <= bus.div_in;
          pend_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      n <= 1'b0;
    else
      n <= p;
  end

  // p & n is zero at each boundary, so only pe moves there
  assign bus.clk_out  = (p & n) | pe;
  assign bus.tick     = tick_q;
  assign bus.div_cur  = div_q;
  assign bus.div_pend = pend_q;
  assign bus.div_err  = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: cadence, duty, divisor updates,
// rejected writes, stop/restart, widest divisor and async reset.
`timescale 1ns/1ps
module tb_clk_div_prog;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  clk_div_prog_if #(.WIDTH(8)) bus ();

  clk_div_prog #(
    .WIDTH     (8),
    .RESET_DIV (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic half_step();
    @(clk);
    #1;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (bus.tick !== 1'b1 && k < 600);
    if (bus.tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: no tick within %0d cycles", k);
    end
  endtask

  task automatic measure(output int hi, output int per);
    int k;
    hi  = 0;
    per = 0;
    k   = 0;
    while (bus.clk_out !== 1'b0 && k < 2000) begin half_step(); k++; end
    while (bus.clk_out !== 1'b1 && k < 2000) begin half_step(); k++; end
    while (bus.clk_out === 1'b1 && k < 2000) begin hi++; half_step(); k++; end
    per = hi;
    while (bus.clk_out === 1'b0 && k < 2000) begin per++; half_step(); k++; end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL measure: clk_out edge timeout");
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.clk_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_clk_out: got %b expected 0", bus.clk_out);
    end
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick: got %b expected 0", bus.tick);
    end
    checks++;
    if (bus.div_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_div_err: got %b expected 0", bus.div_err);
    end
    checks++;
    if (bus.div_pend !== 1'b0) begin
      errors++;
      $display("FAIL rst_div_pend: got %b expected 0", bus.div_pend);
    end
    checks++;
    if (bus.div_cur !== 8'd3) begin
      errors++;
      $display("FAIL rst_div_cur: got %0d expected 3", bus.div_cur);
    end
    rst = 1'b0;
  endtask

  task automatic test_div3();
    int tk;
    int hi;
    int per;
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL start_tick: got %b expected 1", bus.tick);
    end
    tk = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.tick === 1'b1) tk++;
    end
    checks++;
    if (tk != 3) begin
      errors++;
      $display("FAIL div3_ticks: got %0d expected 3", tk);
    end
    measure(hi, per);
    checks++;
    if (hi != 3 || per != 6) begin
      errors++;
      $display("FAIL div3_shape: got hi=%0d per=%0d half-cycles expected 3 6", hi, per);
    end
    checks++;
    if (bus.div_cur !== 8'd3) begin
      errors++;
      $display("FAIL div3_cur: got %0d expected 3", bus.div_cur);
    end
  endtask

  task automatic test_div_change();
    int hi;
    int per;
    wait_tick();
    bus.div_wr = 1'b1;
    bus.div_in = 8'd4;
    step();
    bus.div_wr = 1'b0;
    checks++;
    if (bus.div_pend !== 1'b1 || bus.div_cur !== 8'd3) begin
      errors++;
      $display("FAIL chg_pend1: got pend=%b cur=%0d expected 1 3", bus.div_pend, bus.div_cur);
    end
    step();
    checks++;
    if (bus.div_pend !== 1'b1 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL chg_pend2: got pend=%b tick=%b expected 1 0", bus.div_pend, bus.tick);
    end
    step();
    checks++;
    if (bus.tick !== 1'b1 || bus.div_cur !== 8'd4 || bus.div_pend !== 1'b0) begin
      errors++;
      $display("FAIL chg_bound: got tick=%b cur=%0d pend=%b expected 1 4 0",
               bus.tick, bus.div_cur, bus.div_pend);
    end
    measure(hi, per);
    checks++;
    if (hi != 4 || per != 8) begin
      errors++;
      $display("FAIL div4_shape: got hi=%0d per=%0d expected 4 8", hi, per);
    end
  endtask

  task automatic test_bad_write();
    int hi;
    int per;
    wait_tick();
    bus.div_wr = 1'b1;
    bus.div_in = 8'd1;
    step();
    bus.div_wr = 1'b0;
    checks++;
    if (bus.div_err !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: got %b expected 1", bus.div_err);
    end
    step();
    checks++;
    if (bus.div_err !== 1'b0 || bus.div_cur !== 8'd4 || bus.div_pend !== 1'b0) begin
      errors++;
      $display("FAIL err_after: got err=%b cur=%0d pend=%b expected 0 4 0",
               bus.div_err, bus.div_cur, bus.div_pend);
    end
    step();
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL err_cnt3_tick: got %b expected 0", bus.tick);
    end
    step();
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL err_cadence: got tick=%b expected 1", bus.tick);
    end
    measure(hi, per);
    checks++;
    if (hi != 4 || per != 8) begin
      errors++;
      $display("FAIL err_shape: got hi=%0d per=%0d expected 4 8", hi, per);
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    int per;
    wait_tick();
    bus.div_wr = 1'b1;
    bus.div_in = 8'd7;
    step();
    bus.div_in = 8'd9;
    step();
    bus.div_wr = 1'b0;
    checks++;
    if (bus.div_pend !== 1'b1 || bus.div_cur !== 8'd4) begin
      errors++;
      $display("FAIL b2b_pend: got pend=%b cur=%0d expected 1 4", bus.div_pend, bus.div_cur);
    end
    step();
    step();
    checks++;
    if (bus.tick !== 1'b1 || bus.div_cur !== 8'd9 || bus.div_pend !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last: got tick=%b cur=%0d pend=%b expected 1 9 0",
               bus.tick, bus.div_cur, bus.div_pend);
    end
    repeat (8) step();
    checks++;
    if (bus.tick !== 1'b0 || bus.clk_out !== 1'b0) begin
      errors++;
      $display("FAIL div9_tail: got tick=%b clk_out=%b expected 0 0", bus.tick, bus.clk_out);
    end
    bus.div_wr = 1'b1;
    bus.div_in = 8'd5;
    step();
    bus.div_wr = 1'b0;
    checks++;
    if (bus.tick !== 1'b1 || bus.div_cur !== 8'd5 || bus.div_pend !== 1'b0) begin
      errors++;
      $display("FAIL bound_wr: got tick=%b cur=%0d pend=%b expected 1 5 0",
               bus.tick, bus.div_cur, bus.div_pend);
    end
    measure(hi, per);
    checks++;
    if (hi != 5 || per != 10) begin
      errors++;
      $display("FAIL div5_shape: got hi=%0d per=%0d expected 5 10", hi, per);
    end
  endtask

  task automatic test_stop();
    int hi;
    int tk;
    wait_tick();
    bus.div_wr = 1'b1;
    bus.div_in = 8'd8;
    step();
    bus.div_wr = 1'b0;
    wait_tick();
    checks++;
    if (bus.div_cur !== 8'd8) begin
      errors++;
      $display("FAIL stop_cur: got %0d expected 8", bus.div_cur);
    end
    hi = (bus.clk_out === 1'b1) ? 1 : 0;
    tk = 0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (bus.clk_out === 1'b1) hi++;
      if (bus.tick === 1'b1) tk++;
      if (i == 1) bus.en = 1'b0;
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL stop_high: got %0d cycles expected 4", hi);
    end
    checks++;
    if (tk != 0 || bus.clk_out !== 1'b0) begin
      errors++;
      $display("FAIL stop_parked: got ticks=%0d clk_out=%b expected 0 0", tk, bus.clk_out);
    end
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.clk_out !== 1'b1 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL restart: got clk_out=%b tick=%b expected 1 1", bus.clk_out, bus.tick);
    end
  endtask

  task automatic test_div255_reset();
    int hi;
    int per;
    bus.div_wr = 1'b1;
    bus.div_in = 8'd255;
    step();
    bus.div_wr = 1'b0;
    wait_tick();
    checks++;
    if (bus.div_cur !== 8'd255) begin
      errors++;
      $display("FAIL max_cur: got %0d expected 255", bus.div_cur);
    end
    measure(hi, per);
    checks++;
    if (hi != 255 || per != 510) begin
      errors++;
      $display("FAIL div255_shape: got hi=%0d per=%0d expected 255 510", hi, per);
    end
    repeat (20) half_step();
    checks++;
    if (bus.clk_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_high: got %b expected 1", bus.clk_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.clk_out !== 1'b0 || bus.tick !== 1'b0 || bus.div_err !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_out: got clk_out=%b tick=%b err=%b expected 0 0 0",
               bus.clk_out, bus.tick, bus.div_err);
    end
    checks++;
    if (bus.div_cur !== 8'd3 || bus.div_pend !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_div: got cur=%0d pend=%b expected 3 0", bus.div_cur, bus.div_pend);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (bus.tick !== 1'b1 || bus.div_cur !== 8'd3) begin
      errors++;
      $display("FAIL post_rst_start: got tick=%b cur=%0d expected 1 3", bus.tick, bus.div_cur);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_div3();
    test_div_change();
    test_bad_write();
    test_back_to_back();
    test_stop();
    test_div255_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
